// File: rtl/axi_pkg.sv
// Shared AXI3 types and helpers for the slave memory and its address generator.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned log2_ceil(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-beat address helper: next burst address, memory word index and error flags
// for the beat currently addressed by addr_i.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = 4,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned IDX_W      = 10
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic [IDX_W-1:0]      word_idx_o,
  output logic                  range_err_o,
  output logic                  xfer_err_o
);

  localparam int unsigned SZ_MAX = log2_ceil(STRB_WIDTH);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] word_full;

  assign step        = ADDR_WIDTH'(1) << size_i;
  assign word_full   = addr_i >> SZ_MAX;
  assign word_idx_o  = word_full[IDX_W-1:0];
  assign range_err_o = word_full >= ADDR_WIDTH'(MEM_WORDS);
  // WRAP and the reserved encoding are rejected outright, as is a beat wider than the bus.
  assign xfer_err_o  = (size_i > 3'(SZ_MAX)) ||
                       !((burst_i == BURST_FIXED) || (burst_i == BURST_INCR));

  always_comb begin
    next_addr_o = addr_i;
    if (burst_i == BURST_INCR) begin
      next_addr_o = (addr_i & ~(step - ADDR_WIDTH'(1))) + step;
    end
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI3 slave with byte-laned internal memory; independent write and read FSMs,
// one outstanding burst per direction.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned MEM_WORDS  = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ID_WIDTH-1:0]   AWID,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [LEN_WIDTH-1:0]  AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [ID_WIDTH-1:0]   WID,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [ID_WIDTH-1:0]   BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [LEN_WIDTH-1:0]  ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // active_q keeps the ready outputs low while in reset and for the edge it is released on.
  logic active_q;

  wr_state_e             wstate_q, wstate_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [LEN_WIDTH-1:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d, bresp_q, bresp_d;

  rd_state_e             rstate_q, rstate_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [LEN_WIDTH-1:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d, rresp_q, rresp_d;
  logic                  rzero_q, rzero_d;

  logic                  awready, wready, bvalid, arready, rvalid;
  logic                  mem_we, mem_re, r_fetch;
  logic [1:0]            w_beat_resp;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic [ADDR_WIDTH-1:0] w_next, r_next, r_gen_addr;
  logic [IDX_W-1:0]      w_idx, r_idx;
  logic                  w_range_err, w_xfer_err, r_range_err, r_xfer_err;
  logic [2:0]            r_gen_size;
  logic [1:0]            r_gen_burst;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH), .MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W)
  ) u_wr_addr (
    .addr_i(waddr_q), .size_i(wsize_q), .burst_i(wburst_q),
    .next_addr_o(w_next), .word_idx_o(w_idx), .range_err_o(w_range_err), .xfer_err_o(w_xfer_err)
  );

  // In idle the read side addresses straight from the AR channel so the first beat
  // is fetched on the AR handshake edge.
  assign r_gen_addr  = (rstate_q == R_IDLE) ? ARADDR  : raddr_q;
  assign r_gen_size  = (rstate_q == R_IDLE) ? ARSIZE  : rsize_q;
  assign r_gen_burst = (rstate_q == R_IDLE) ? ARBURST : rburst_q;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH), .MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W)
  ) u_rd_addr (
    .addr_i(r_gen_addr), .size_i(r_gen_size), .burst_i(r_gen_burst),
    .next_addr_o(r_next), .word_idx_o(r_idx), .range_err_o(r_range_err), .xfer_err_o(r_xfer_err)
  );

  always_comb begin
    wstate_d    = wstate_q;
    wid_d       = wid_q;
    waddr_d     = waddr_q;
    wlen_d      = wlen_q;
    wsize_d     = wsize_q;
    wburst_d    = wburst_q;
    wcnt_d      = wcnt_q;
    bresp_d     = bresp_q;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    mem_we      = 1'b0;
    w_beat_resp = RESP_OKAY;
    case (wstate_q)
      W_IDLE: begin
        awready = active_q;
        if (AWVALID && active_q) begin
          wid_d    = AWID;
          waddr_d  = AWADDR;
          wlen_d   = AWLEN;
          wsize_d  = AWSIZE;
          wburst_d = AWBURST;
          wcnt_d   = '0;
          bresp_d  = RESP_OKAY;
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (WVALID) begin
          if (w_xfer_err)       w_beat_resp = RESP_SLVERR;
          else if (w_range_err) w_beat_resp = RESP_DECERR;
          else if (WID != wid_q) w_beat_resp = RESP_SLVERR;
          else                   mem_we      = 1'b1;
          if ((WLAST != (wcnt_q == wlen_q)) && (w_beat_resp == RESP_OKAY)) begin
            w_beat_resp = RESP_SLVERR;
          end
          // Encodings order by precedence, so the sticky response is a running max.
          bresp_d = (w_beat_resp > bresp_q) ? w_beat_resp : bresp_q;
          waddr_d = w_next;
          wcnt_d  = wcnt_q + LEN_WIDTH'(1);
          if (wcnt_q == wlen_q) wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (BREADY) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rcnt_d   = rcnt_q;
    rresp_d  = rresp_q;
    rzero_d  = rzero_q;
    arready  = 1'b0;
    rvalid   = 1'b0;
    r_fetch  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        arready = active_q;
        if (ARVALID && active_q) begin
          rid_d    = ARID;
          rlen_d   = ARLEN;
          rsize_d  = ARSIZE;
          rburst_d = ARBURST;
          rcnt_d   = '0;
          r_fetch  = 1'b1;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (RREADY) begin
          if (rcnt_q == rlen_q) begin
            rstate_d = R_IDLE;
          end else begin
            rcnt_d  = rcnt_q + LEN_WIDTH'(1);
            r_fetch = 1'b1;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    mem_re = r_fetch && !r_xfer_err && !r_range_err;
    if (r_fetch) begin
      raddr_d = r_next;
      rzero_d = !mem_re;
      rresp_d = r_xfer_err ? RESP_SLVERR : (r_range_err ? RESP_DECERR : RESP_OKAY);
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      active_q <= 1'b0;
      wstate_q <= W_IDLE;
      wid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      wcnt_q   <= '0;
      bresp_q  <= '0;
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rcnt_q   <= '0;
      rresp_q  <= '0;
      rzero_q  <= 1'b0;
    end else begin
      active_q <= 1'b1;
      wstate_q <= wstate_d;
      wid_q    <= wid_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wsize_q  <= wsize_d;
      wburst_q <= wburst_d;
      wcnt_q   <= wcnt_d;
      bresp_q  <= bresp_d;
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rsize_q  <= rsize_d;
      rburst_q <= rburst_d;
      rcnt_q   <= rcnt_d;
      rresp_q  <= rresp_d;
      rzero_q  <= rzero_d;
    end
  end

  // One byte-wide array per lane keeps strobed writes a plain RAM write enable.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
      logic [7:0] lane_q [MEM_WORDS];
      logic [7:0] lane_rd_q;
      always_ff @(posedge ACLK) begin
        if (mem_we && WSTRB[gi]) lane_q[w_idx] <= WDATA[gi*8 +: 8];
        if (mem_re) lane_rd_q <= lane_q[r_idx];
      end
      assign mem_rdata[gi*8 +: 8] = lane_rd_q;
    end
  endgenerate

  assign AWREADY = awready;
  assign WREADY  = wready;
  assign BVALID  = bvalid;
  assign BID     = bvalid ? wid_q : '0;
  assign BRESP   = bvalid ? bresp_q : '0;
  assign ARREADY = arready;
  assign RVALID  = rvalid;
  assign RID     = rvalid ? rid_q : '0;
  assign RRESP   = rvalid ? rresp_q : '0;
  assign RLAST   = rvalid && (rcnt_q == rlen_q);
  assign RDATA   = (rvalid && !rzero_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: reset, bursts, strobes, throttling, errors, concurrency.
module tb_axi_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [3:0]  AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [7:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [3:0]  WID = '0;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [3:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];
  logic [1:0]  rrbuf [16];
  logic        rlbuf [16];
  logic [3:0]  ridbuf [16];
  int          rbeats;
  logic [1:0]  bresp_s;
  logic [3:0]  bid_s;
  logic [31:0] r0, r1;

  axi_slave_mem dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bt, input logic [3:0] wid,
                          input logic [3:0] strb, output logic [1:0] resp, output logic [3:0] bid);
    for (int t = 0; t < 20 && !AWREADY; t++) step();
    chk("awready_before_aw", AWREADY, 1);
    AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = sz; AWBURST = bt;
    step();
    AWVALID = 1'b0;
    chk("wready_after_aw", WREADY, 1);
    for (int i = 0; i <= int'(len); i++) begin
      WVALID = 1'b1; WDATA = wbuf[i]; WSTRB = strb; WID = wid; WLAST = (i == int'(len));
      step();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk("bvalid_after_last", BVALID, 1);
    resp = BRESP;
    bid = BID;
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    chk("bvalid_clear", BVALID, 0);
    $display("WR id=%0h addr=%08h len=%0d bid=%0h bresp=%0d", id, addr, len, bid, resp);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt, input int mode);
    logic [39:0] held;
    logic        stalled;
    logic        done;
    for (int t = 0; t < 20 && !ARREADY; t++) step();
    chk("arready_before_ar", ARREADY, 1);
    ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = sz; ARBURST = bt;
    step();
    ARVALID = 1'b0;
    chk("rvalid_after_ar", RVALID, 1);
    rbeats = 0;
    done = 1'b0;
    stalled = 1'b0;
    held = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (stalled) chk("r_hold_stable", {RVALID, RLAST, RID, RRESP, RDATA}, held);
      RREADY = (mode == 0) || (c % 3 == 0);
      stalled = RVALID && !RREADY;
      held = {RVALID, RLAST, RID, RRESP, RDATA};
      if (RVALID && RREADY && rbeats < 16) begin
        rbuf[rbeats] = RDATA; rrbuf[rbeats] = RRESP; rlbuf[rbeats] = RLAST; ridbuf[rbeats] = RID;
        rbeats++;
        if (RLAST) done = 1'b1;
      end
      step();
    end
    RREADY = 1'b0;
    chk("r_burst_done", done, 1);
    chk("r_beat_count", rbeats, int'(len) + 1);
    chk("rvalid_clear", RVALID, 0);
    $display("RD id=%0h addr=%08h len=%0d beats=%0d first=%08h rresp0=%0d", id, addr, len, rbeats,
             rbuf[0], rrbuf[0]);
  endtask

  initial begin
    // Reset held for three edges, then released.
    step(); step(); step();
    chk("rst_awready", AWREADY, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    ARESETn = 1'b1;
    step();
    chk("post_rst_awready", AWREADY, 1);
    chk("post_rst_arready", ARREADY, 1);

    // 4-beat INCR write then read back.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
    do_write(4'd5, 32'h10, 8'd3, 3'd2, 2'b01, 4'd5, 4'hF, bresp_s, bid_s);
    chk("t2_bid", bid_s, 5);
    chk("t2_bresp", bresp_s, 0);
    do_read(4'd5, 32'h10, 8'd3, 3'd2, 2'b01, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_rdata", rbuf[i], 32'hA0 + i);
      chk("t2_rresp", rrbuf[i], 0);
      chk("t2_rlast", rlbuf[i], (i == 3) ? 1 : 0);
      chk("t2_rid", ridbuf[i], 5);
    end

    // Byte strobes merge into a previously written word.
    wbuf[0] = 32'hFFFF_FFFF;
    do_write(4'd1, 32'h0, 8'd0, 3'd2, 2'b01, 4'd1, 4'hF, bresp_s, bid_s);
    wbuf[0] = 32'h1234_5678;
    do_write(4'd1, 32'h0, 8'd0, 3'd2, 2'b01, 4'd1, 4'b0101, bresp_s, bid_s);
    do_read(4'd2, 32'h0, 8'd0, 3'd2, 2'b01, 0);
    chk("t3_strobe_merge", rbuf[0], 32'hFF34_FF78);

    // Throttled read: RREADY pattern 1,0,0,1,...
    do_read(4'd3, 32'h10, 8'd3, 3'd2, 2'b01, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_rdata", rbuf[i], 32'hA0 + i);
      chk("t4_rlast", rlbuf[i], (i == 3) ? 1 : 0);
    end

    // Out-of-range write.
    wbuf[0] = 32'h0BAD_0BAD;
    do_write(4'd4, 32'h1000, 8'd0, 3'd2, 2'b01, 4'd4, 4'hF, bresp_s, bid_s);
    chk("t5_decerr", bresp_s, 3);

    // WRAP read: SLVERR on every beat, data zero.
    do_read(4'd7, 32'h10, 8'd1, 3'd2, 2'b10, 0);
    for (int i = 0; i < 2; i++) begin
      chk("t5_wrap_rresp", rrbuf[i], 2);
      chk("t5_wrap_rdata", rbuf[i], 0);
    end

    // WID mismatch leaves memory untouched.
    wbuf[0] = 32'h55AA_55AA;
    do_write(4'd5, 32'h20, 8'd0, 3'd2, 2'b01, 4'd5, 4'hF, bresp_s, bid_s);
    chk("t5_pre_okay", bresp_s, 0);
    wbuf[0] = 32'hDEAD_BEEF;
    do_write(4'd5, 32'h20, 8'd0, 3'd2, 2'b01, 4'd3, 4'hF, bresp_s, bid_s);
    chk("t5_wid_slverr", bresp_s, 2);
    do_read(4'd5, 32'h20, 8'd0, 3'd2, 2'b01, 0);
    chk("t5_mem_unchanged", rbuf[0], 32'h55AA_55AA);

    // Concurrent AW/AR; write to 0x14 lands on the same edge the read fetches 0x14.
    chk("t6_awready", AWREADY, 1);
    chk("t6_arready", ARREADY, 1);
    AWVALID = 1'b1; AWID = 4'd9; AWADDR = 32'h14; AWLEN = 8'd0; AWSIZE = 3'd2; AWBURST = 2'b01;
    ARVALID = 1'b1; ARID = 4'd6; ARADDR = 32'h10; ARLEN = 8'd1; ARSIZE = 3'd2; ARBURST = 2'b01;
    step();
    AWVALID = 1'b0; ARVALID = 1'b0;
    chk("t6_rvalid", RVALID, 1);
    chk("t6_wready", WREADY, 1);
    r0 = RDATA;
    WVALID = 1'b1; WDATA = 32'hC1; WSTRB = 4'hF; WID = 4'd9; WLAST = 1'b1;
    RREADY = 1'b1;
    step();
    WVALID = 1'b0; WLAST = 1'b0;
    chk("t6_bvalid", BVALID, 1);
    chk("t6_rlast", RLAST, 1);
    r1 = RDATA;
    step();
    RREADY = 1'b0;
    chk("t6_rvalid_clear", RVALID, 0);
    for (int k = 0; k < 5; k++) begin
      chk("t6_b_held", {BVALID, BID, BRESP}, {1'b1, 4'd9, 2'd0});
      step();
    end
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    chk("t6_bvalid_clear", BVALID, 0);
    chk("t6_read_beat0", r0, 32'hA0);
    chk("t6_read_old_data", r1, 32'hA1);
    $display("CC awid=9 arid=6 r0=%08h r1=%08h", r0, r1);
    do_read(4'd6, 32'h14, 8'd0, 3'd2, 2'b01, 0);
    chk("t6_new_data", rbuf[0], 32'hC1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
